multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-003 SHALL have ports op and funct, input, 6 each, opcode and function fields from the instruction register, stable from DECODE onward.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory completion; used only when MC_CTRL_STALL_EN is defined.
REQ-006 SHALL have ports pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, ext, illegal, output, 1 each.
REQ-007 SHALL have ports reg_dst, alu_src_a, alu_src_b, mem2reg, pc_src, output, 2 each, and alu_ctrl, output, 5.
REQ-008 SHALL have port state, output, 4, current state for debug.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
REQ-010 SHALL assert the following in FETCH: mem_rd=1, ir_wr=1, pc_wr=1, alu_src_a=10 (PC), alu_src_b=11 (const 4), alu_ctrl=ADD, pc_src=00. The next state is DECODE.
REQ-011 SHALL, in DECODE, go to EXEC_R (op R), EXEC_I (ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI), MEM_ADDR (LW/SW), BRANCH (BEQ/BNE), or JUMP (J); on any other op, or an unsupported funct, pulse illegal for 1 cycle and go to FETCH with no writes.
REQ-012 SHALL, in EXEC_R, drive alu_src_a=00, alu_src_b=01 for SLL/SRL/SRA and 00 otherwise. alu_ctrl SHALL be: ADD/ADDU 00000, SUB/SUBU 00001, SLL 00010, SRL 00011, SLT 00100, AND 00101, OR 00110, XOR 00111, SLTU 01000, SRA 01001, NOR 01010. The next state is WB_ALU with reg_dst=01.
REQ-013 SHALL, in EXEC_I, drive alu_src_b=10 with ext=1 only for SLTI. LUI SHALL use alu_src_a=01 and SLL; other ops SHALL use the ALU code matching their R counterpart. The next state is WB_ALU with reg_dst=00.
REQ-014 SHALL, in MEM_ADDR, drive ADD, alu_src_b=10, ext=1, then go to MEM_RD (LW) or MEM_WR (SW).
REQ-015 SHALL, in MEM_RD, assert mem_rd and go to WB_MEM; in MEM_WR, it SHALL assert mem_wr and go to FETCH.
REQ-016 SHALL, in WB_ALU, assert reg_wr with mem2reg=00; in WB_MEM, it SHALL assert reg_wr with mem2reg=01, reg_dst=00. Both states SHALL go to FETCH.
REQ-017 SHALL, in BRANCH, drive SUB, alu_src_b=00, pc_src=01, and set pc_wr=zero for BEQ or pc_wr=~zero for BNE. In JUMP it SHALL drive pc_wr=1, pc_src=10. Both states SHALL go to FETCH.
REQ-018 SHALL hold every write enable at 0 in any state where it is not listed above.
REQ-019 SHALL give these latencies (no stall): R/I-ALU 4 cycles, LW 5, SW 4, BEQ/BNE/J 3.
REQ-020 SHALL treat an unused state encoding as FETCH with all enables 0.

Reset
REQ-021 SHALL, while rst=1, force the state to FETCH immediately (asynchronously), hold all write enables and illegal at 0, and hold the 2-bit and 5-bit outputs at 0.
REQ-022 SHALL, when reset is asserted mid-instruction (e.g. MEM_WR), drop mem_wr in the same cycle; the first rising edge after rst deasserts SHALL begin FETCH.

Configuration
REQ-023 SHALL, with MC_CTRL_STALL_EN defined, hold FETCH, MEM_RD and MEM_WR while mem_ready=0. The read/write strobe SHALL stay asserted; ir_wr and pc_wr SHALL be asserted only in the cycle mem_ready=1. The state SHALL advance on that edge.
REQ-024 SHALL, without MC_CTRL_STALL_EN, ignore mem_ready and treat every memory state as single-cycle.

Structure
REQ-025 SHALL place opcode, funct, ALU-code and state-encoding constants in shared package mips_pkg.
REQ-026 SHALL place the funct-to-alu_ctrl lookup in sub-module alu_decode, reused by EXEC_R and EXEC_I.

Verification
REQ-027 SHALL cover: op=000000, funct=100000 -> states F,D,EX_R,WB_ALU; reg_wr=1, reg_dst=01 in cycle 4, alu_ctrl=00000 in cycle 3.
REQ-028 SHALL cover: op=100011 (LW), MC_CTRL_STALL_EN, mem_ready low for 2 cycles in MEM_RD -> mem_rd held 3 cycles; reg_wr, mem2reg=01 after.
REQ-029 SHALL cover: op=000101 (BNE), zero=1 -> pc_wr=0 in BRANCH; with zero=0 -> pc_wr=1, pc_src=01.
REQ-030 SHALL cover: op=111111 -> illegal pulses 1 cycle after DECODE, next state FETCH, no reg_wr/mem_wr.
REQ-031 SHALL cover: rst asserted during MEM_WR of SW (op=101011) -> mem_wr=0 without a clock edge; state=FETCH.
REQ-032 SHALL cover: op=001111 (LUI) -> alu_src_a=01, alu_src_b=10, alu_ctrl=00010, reg_dst=00.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU codes, mux selects, FSM states and the packed control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_SRL  = 5'b00011;
    localparam logic [4:0] ALU_SLT  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_XOR  = 5'b00111;
    localparam logic [4:0] ALU_SLTU = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_NOR  = 5'b01010;

    localparam logic [1:0] SRC_A_REG   = 2'b00;
    localparam logic [1:0] SRC_A_UPPER = 2'b01;
    localparam logic [1:0] SRC_A_PC    = 2'b10;
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_SHAMT = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_FOUR  = 2'b11;
    localparam logic [1:0] DST_RT      = 2'b00;
    localparam logic [1:0] DST_RD      = 2'b01;
    localparam logic [1:0] M2R_ALU     = 2'b00;
    localparam logic [1:0] M2R_MEM     = 2'b01;
    localparam logic [1:0] PC_SEQ      = 2'b00;
    localparam logic [1:0] PC_BRANCH   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       ext;
        logic       illegal;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] mem2reg;
        logic [1:0] pc_src;
        logic [4:0] alu_ctrl;
    } ctrl_t;

    // I-type ALU ops reuse the funct lookup through their R-type counterpart.
    function automatic logic [5:0] imm_funct(input logic [5:0] op);
        case (op)
            OP_SLTI:  return F_SLT;
            OP_SLTIU: return F_SLTU;
            OP_ANDI:  return F_AND;
            OP_ORI:   return F_OR;
            OP_XORI:  return F_XOR;
            OP_LUI:   return F_SLL;
            default:  return F_ADD;
        endcase
    endfunction

    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Funct-field to ALU-code lookup; valid drops for funct values the ALU
// does not implement.
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] alu_ctrl,
    output logic       valid
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
            F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
            F_SLL:         alu_ctrl = ALU_SLL;
            F_SRL:         alu_ctrl = ALU_SRL;
            F_SRA:         alu_ctrl = ALU_SRA;
            F_SLT:         alu_ctrl = ALU_SLT;
            F_SLTU:        alu_ctrl = ALU_SLTU;
            F_AND:         alu_ctrl = ALU_AND;
            F_OR:          alu_ctrl = ALU_OR;
            F_XOR:         alu_ctrl = ALU_XOR;
            F_NOR:         alu_ctrl = ALU_NOR;
            default:       valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a multicycle MIPS datapath. Define MC_CTRL_STALL_EN
// to hold FETCH/MEM_RD/MEM_WR until mem_ready; otherwise memory is single-cycle.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       ext,
    output logic       illegal,
    output logic [1:0] reg_dst,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] mem2reg,
    output logic [1:0] pc_src,
    output logic [4:0] alu_ctrl,
    output logic [3:0] state
);

    state_t     cur, nxt;
    ctrl_t      ctl;
    logic       illegal_q;
    logic       bad_instr;
    logic       mem_go;
    logic [5:0] dec_funct;
    logic [4:0] dec_alu;
    logic       dec_valid;

`ifdef MC_CTRL_STALL_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go           = 1'b1;
`endif

    assign dec_funct = (op == OP_RTYPE) ? funct : imm_funct(op);

    alu_decode u_alu_decode (
        .funct    (dec_funct),
        .alu_ctrl (dec_alu),
        .valid    (dec_valid)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur       <= nxt;
            illegal_q <= bad_instr;
        end
    end

    always_comb begin
        nxt         = S_FETCH;
        ctl         = '0;
        bad_instr   = 1'b0;
        ctl.illegal = illegal_q;
        case (cur)
            S_FETCH: begin
                ctl.mem_rd    = 1'b1;
                ctl.ir_wr     = mem_go;
                ctl.pc_wr     = mem_go;
                ctl.alu_src_a = SRC_A_PC;
                ctl.alu_src_b = SRC_B_FOUR;
                ctl.alu_ctrl  = ALU_ADD;
                nxt           = mem_go ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (dec_valid) nxt = S_EXEC_R;
                        else           bad_instr = 1'b1;
                    end
                    OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: nxt = S_EXEC_I;
                    OP_LW, OP_SW:            nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:          nxt = S_BRANCH;
                    OP_J:                    nxt = S_JUMP;
                    default:                 bad_instr = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = SRC_A_REG;
                ctl.alu_src_b = is_shift(funct) ? SRC_B_SHAMT : SRC_B_REG;
                ctl.alu_ctrl  = dec_alu;
                nxt           = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = (op == OP_LUI) ? SRC_A_UPPER : SRC_A_REG;
                ctl.alu_src_b = SRC_B_IMM;
                ctl.ext       = (op == OP_SLTI);
                ctl.alu_ctrl  = dec_alu;
                nxt           = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_b = SRC_B_IMM;
                ctl.ext       = 1'b1;
                ctl.alu_ctrl  = ALU_ADD;
                nxt           = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctl.mem_rd = 1'b1;
                nxt        = mem_go ? S_WB_MEM : S_MEM_RD;
            end
            S_MEM_WR: begin
                ctl.mem_wr = 1'b1;
                nxt        = mem_go ? S_FETCH : S_MEM_WR;
            end
            S_WB_ALU: begin
                ctl.reg_wr  = 1'b1;
                ctl.mem2reg = M2R_ALU;
                ctl.reg_dst = (op == OP_RTYPE) ? DST_RD : DST_RT;
            end
            S_WB_MEM: begin
                ctl.reg_wr  = 1'b1;
                ctl.mem2reg = M2R_MEM;
                ctl.reg_dst = DST_RT;
            end
            S_BRANCH: begin
                ctl.alu_src_b = SRC_B_REG;
                ctl.alu_ctrl  = ALU_SUB;
                ctl.pc_src    = PC_BRANCH;
                ctl.pc_wr     = (op == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                ctl.pc_wr  = 1'b1;
                ctl.pc_src = PC_JUMP;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Reset gates the outputs directly so strobes drop without waiting for a clock.
    assign {pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, ext, illegal,
            reg_dst, alu_src_a, alu_src_b, mem2reg, pc_src, alu_ctrl} = rst ? '0 : ctl;
    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven check of multicycle_ctrl plus hand-written stall and
// mid-instruction reset sequences.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       ext;
        logic       illegal;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] mem2reg;
        logic [1:0] pc_src;
        logic [4:0] alu_ctrl;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mem_ready;
        logic [3:0] st;
        ctl_t       exp;
    } vec_t;

`ifdef MC_CTRL_STALL_EN
    localparam logic MR = 1'b1;
`else
    localparam logic MR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, ext, illegal;
    logic [1:0] reg_dst, alu_src_a, alu_src_b, mem2reg, pc_src;
    logic [4:0] alu_ctrl;
    logic [3:0] state;
    ctl_t       act;

    vec_t vecs[96];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .reg_wr    (reg_wr),
        .ext       (ext),
        .illegal   (illegal),
        .reg_dst   (reg_dst),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .mem2reg   (mem2reg),
        .pc_src    (pc_src),
        .alu_ctrl  (alu_ctrl),
        .state     (state)
    );

    assign act = {pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, ext, illegal,
                  reg_dst, alu_src_a, alu_src_b, mem2reg, pc_src, alu_ctrl};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    function automatic ctl_t k_fetch(input logic ill);
        ctl_t k = '0;
        k.pc_wr     = 1'b1;
        k.ir_wr     = 1'b1;
        k.mem_rd    = 1'b1;
        k.alu_src_a = 2'b10;
        k.alu_src_b = 2'b11;
        k.illegal   = ill;
        return k;
    endfunction

    // Apply inputs just after a falling edge, compare, then wait for the next falling edge.
    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic mr, input logic [3:0] st, input ctl_t e);
        op = o; funct = f; zero = z; mem_ready = mr;
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_ctl"}, 32'(act), 32'(e));
        @(negedge clk);
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] st, input ctl_t e);
        vecs[n_vec].op        = o;
        vecs[n_vec].funct     = f;
        vecs[n_vec].zero      = z;
        vecs[n_vec].mem_ready = MR;
        vecs[n_vec].st        = st;
        vecs[n_vec].exp       = e;
        n_vec++;
    endtask

    task automatic add_fd(input logic [5:0] o, input logic [5:0] f, input logic z, input logic ill);
        add(o, f, z, 4'd0, k_fetch(ill));
        add(o, f, z, 4'd1, '0);
    endtask

    task automatic add_r(input logic [5:0] f, input logic [4:0] alu, input logic sh, input logic ill);
        ctl_t e;
        add_fd(6'b000000, f, 1'b0, ill);
        e = '0; e.alu_ctrl = alu; e.alu_src_b = sh ? 2'b01 : 2'b00;
        add(6'b000000, f, 1'b0, 4'd2, e);
        e = '0; e.reg_wr = 1'b1; e.reg_dst = 2'b01;
        add(6'b000000, f, 1'b0, 4'd7, e);
    endtask

    task automatic add_i(input logic [5:0] o, input logic [4:0] alu, input logic [1:0] a, input logic x);
        ctl_t e;
        add_fd(o, 6'h3f, 1'b0, 1'b0);
        e = '0; e.alu_ctrl = alu; e.alu_src_a = a; e.alu_src_b = 2'b10; e.ext = x;
        add(o, 6'h3f, 1'b0, 4'd3, e);
        e = '0; e.reg_wr = 1'b1;
        add(o, 6'h3f, 1'b0, 4'd7, e);
    endtask

    task automatic add_br(input logic [5:0] o, input logic z, input logic pcw);
        ctl_t e;
        add_fd(o, 6'h00, z, 1'b0);
        e = '0; e.alu_ctrl = 5'b00001; e.pc_src = 2'b01; e.pc_wr = pcw;
        add(o, 6'h00, z, 4'd9, e);
    endtask

    initial begin
        ctl_t e;
        ctl_t ma;
        int   rd_cycles;

        ma = '0; ma.alu_src_b = 2'b10; ma.ext = 1'b1;

        add_r(6'b100000, 5'b00000, 1'b0, 1'b0);   // ADD
        add_r(6'b000000, 5'b00010, 1'b1, 1'b0);   // SLL
        add_r(6'b000011, 5'b01001, 1'b1, 1'b0);   // SRA
        add_r(6'b100011, 5'b00001, 1'b0, 1'b0);   // SUBU
        add_r(6'b100111, 5'b01010, 1'b0, 1'b0);   // NOR
        add_r(6'b101011, 5'b01000, 1'b0, 1'b0);   // SLTU
        add_i(6'b001111, 5'b00010, 2'b01, 1'b0);  // LUI
        add_i(6'b001010, 5'b00100, 2'b00, 1'b1);  // SLTI
        add_i(6'b001011, 5'b01000, 2'b00, 1'b0);  // SLTIU
        add_i(6'b001100, 5'b00101, 2'b00, 1'b0);  // ANDI
        add_i(6'b001001, 5'b00000, 2'b00, 1'b0);  // ADDIU
        add_fd(6'b100011, 6'h00, 1'b0, 1'b0);     // LW
        add(6'b100011, 6'h00, 1'b0, 4'd4, ma);
        e = '0; e.mem_rd = 1'b1;
        add(6'b100011, 6'h00, 1'b0, 4'd5, e);
        e = '0; e.reg_wr = 1'b1; e.mem2reg = 2'b01;
        add(6'b100011, 6'h00, 1'b0, 4'd8, e);
        add_fd(6'b101011, 6'h00, 1'b0, 1'b0);     // SW
        add(6'b101011, 6'h00, 1'b0, 4'd4, ma);
        e = '0; e.mem_wr = 1'b1;
        add(6'b101011, 6'h00, 1'b0, 4'd6, e);
        add_br(6'b000101, 1'b1, 1'b0);            // BNE taken-not
        add_br(6'b000101, 1'b0, 1'b1);            // BNE taken
        add_br(6'b000100, 1'b1, 1'b1);            // BEQ taken
        add_br(6'b000100, 1'b0, 1'b0);            // BEQ not taken
        add_fd(6'b000010, 6'h00, 1'b0, 1'b0);     // J
        e = '0; e.pc_wr = 1'b1; e.pc_src = 2'b10;
        add(6'b000010, 6'h00, 1'b0, 4'd10, e);
        add_fd(6'b111111, 6'h00, 1'b0, 1'b0);     // bad opcode
        add_fd(6'b000000, 6'b000001, 1'b0, 1'b1); // bad funct; FETCH shows previous illegal
        add_r(6'b100000, 5'b00000, 1'b0, 1'b1);   // ADD; FETCH shows bad-funct illegal

        // Reset state: outputs all zero even though the state is FETCH.
        #1 rst = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctl", 32'(act), 32'd0);
        @(posedge clk); #1;
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_ctl", 32'(act), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < n_vec; i++)
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].funct, vecs[i].zero,
                 vecs[i].mem_ready, vecs[i].st, vecs[i].exp);

`ifdef MC_CTRL_STALL_EN
        // LW with FETCH stalled once and MEM_RD stalled twice.
        e = k_fetch(1'b0); e.ir_wr = 1'b0; e.pc_wr = 1'b0;
        step("stl_f0", 6'b100011, 6'h00, 1'b0, 1'b0, 4'd0, e);
        step("stl_f1", 6'b100011, 6'h00, 1'b0, 1'b1, 4'd0, k_fetch(1'b0));
        step("stl_d", 6'b100011, 6'h00, 1'b0, 1'b1, 4'd1, '0);
        step("stl_ma", 6'b100011, 6'h00, 1'b0, 1'b1, 4'd4, ma);
        rd_cycles = 0;
        e = '0; e.mem_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (mem_rd) rd_cycles++;
            step($sformatf("stl_rd%0d", k), 6'b100011, 6'h00, 1'b0, (k == 2), 4'd5, e);
        end
        check("stl_rd_cycles", 32'(rd_cycles), 32'd3);
        e = '0; e.reg_wr = 1'b1; e.mem2reg = 2'b01;
        step("stl_wb", 6'b100011, 6'h00, 1'b0, 1'b1, 4'd8, e);
        // SW with MEM_WR stalled once.
        step("stw_f", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd0, k_fetch(1'b0));
        step("stw_d", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd1, '0);
        step("stw_ma", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd4, ma);
        e = '0; e.mem_wr = 1'b1;
        step("stw_w0", 6'b101011, 6'h00, 1'b0, 1'b0, 4'd6, e);
        step("stw_w1", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd6, e);
`else
        // mem_ready low throughout: LW still completes in 5 cycles.
        rd_cycles = 0;
        step("nst_f", 6'b100011, 6'h00, 1'b0, 1'b0, 4'd0, k_fetch(1'b0));
        step("nst_d", 6'b100011, 6'h00, 1'b0, 1'b0, 4'd1, '0);
        step("nst_ma", 6'b100011, 6'h00, 1'b0, 1'b0, 4'd4, ma);
        if (mem_rd) rd_cycles++;
        e = '0; e.mem_rd = 1'b1;
        step("nst_rd", 6'b100011, 6'h00, 1'b0, 1'b0, 4'd5, e);
        check("nst_rd_cycles", 32'(rd_cycles), 32'd1);
        e = '0; e.reg_wr = 1'b1; e.mem2reg = 2'b01;
        step("nst_wb", 6'b100011, 6'h00, 1'b0, 1'b0, 4'd8, e);
`endif

        // Reset asserted in the middle of SW's MEM_WR cycle.
        step("rsw_f", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd0, k_fetch(1'b0));
        step("rsw_d", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd1, '0);
        step("rsw_ma", 6'b101011, 6'h00, 1'b0, 1'b1, 4'd4, ma);
        #1;
        check("rsw_pre_state", 32'(state), 32'd6);
        check("rsw_pre_mem_wr", 32'(mem_wr), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rsw_async_mem_wr", 32'(mem_wr), 32'd0);
        check("rsw_async_state", 32'(state), 32'd0);
        check("rsw_async_ctl", 32'(act), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("rsw_post_f", 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd0, k_fetch(1'b0));
        step("rsw_post_d", 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
